// File: rtl/pe_stream_feeder.sv
// Multi-channel burst stream feeder for the PE array, with all-done post-delay start_psum_out pulse; optional per-channel checksum under PE_FEEDER_CHECKSUM_EN.
// Latency: first data_en one cycle after the accepted start edge; start_psum_out post_delay+1 cycles after all ch_done read 1.
// Backpressure: fifo_full[ch] gates data_en[ch] combinationally; the word and counters freeze while full, with no timeout.
module pe_stream_feeder #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NUM_CH-1:0]              cfg_ch_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   cfg_base,
    input  logic [NUM_CH*CNT_WIDTH-1:0]    cfg_burst_len,
    input  logic [NUM_CH*CNT_WIDTH-1:0]    cfg_num_bursts,
    input  logic [NUM_CH*CNT_WIDTH-1:0]    cfg_gap,
    input  logic [CNT_WIDTH-1:0]           cfg_post_delay,
    input  logic [NUM_CH-1:0]              fifo_full,
    output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
    output logic [NUM_CH-1:0]              data_en,
    output logic [NUM_CH-1:0]              ch_done,
    output logic                           busy,
    output logic                           start_psum_out
`ifdef PE_FEEDER_CHECKSUM_EN
    ,
    output logic [NUM_CH*(DATA_WIDTH+CNT_WIDTH)-1:0] checksum
`endif
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {C_IDLE, C_BURST, C_GAP, C_DONE} ch_state_t;
    typedef enum logic [1:0] {G_IDLE, G_RUN, G_WAIT, G_PULSE} g_state_t;

    g_state_t              g_state;
    logic [CNT_WIDTH-1:0]  post_dly;
    logic [CNT_WIDTH-1:0]  dly_cnt;
    logic                  start_ok;

    // A start is only honoured from global idle, and abort always wins.
    assign start_ok = start & ~abort & (g_state == G_IDLE);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gen_ch
        ch_state_t             state;
        logic [DATA_WIDTH-1:0] word;
        logic [CNT_WIDTH-1:0]  len_q, nb_q, gap_q;
        logic [CNT_WIDTH-1:0]  word_cnt, burst_cnt, gap_cnt;
        logic                  xfer;

        assign xfer = (state == C_BURST) & ~fifo_full[ch];
        assign data_en[ch] = xfer;
        assign ch_done[ch] = (state == C_DONE);
        assign data_out[ch*DATA_WIDTH +: DATA_WIDTH] = word;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= C_IDLE;
                word      <= '0;
                len_q     <= '0;
                nb_q      <= '0;
                gap_q     <= '0;
                word_cnt  <= '0;
                burst_cnt <= '0;
                gap_cnt   <= '0;
            end else if (abort) begin
                // word deliberately keeps its last value across an abort
                state     <= C_IDLE;
                word_cnt  <= '0;
                burst_cnt <= '0;
                gap_cnt   <= '0;
            end else if (start_ok) begin
                len_q     <= cfg_burst_len[ch*CNT_WIDTH +: CNT_WIDTH];
                nb_q      <= cfg_num_bursts[ch*CNT_WIDTH +: CNT_WIDTH];
                gap_q     <= cfg_gap[ch*CNT_WIDTH +: CNT_WIDTH];
                word_cnt  <= '0;
                burst_cnt <= '0;
                gap_cnt   <= '0;
                if (cfg_ch_en[ch] &&
                    cfg_burst_len[ch*CNT_WIDTH +: CNT_WIDTH] != '0 &&
                    cfg_num_bursts[ch*CNT_WIDTH +: CNT_WIDTH] != '0) begin
                    state <= C_BURST;
                    word  <= cfg_base[ch*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    state <= C_DONE;
                end
            end else begin
                case (state)
                    C_BURST: begin
                        if (xfer) begin
                            word <= word + DATA_ONE;
                            if (word_cnt == len_q - CNT_ONE) begin
                                word_cnt  <= '0;
                                burst_cnt <= burst_cnt + CNT_ONE;
                                if (burst_cnt == nb_q - CNT_ONE) begin
                                    state <= C_DONE;
                                end else if (gap_q != '0) begin
                                    state   <= C_GAP;
                                    gap_cnt <= '0;
                                end
                            end else begin
                                word_cnt <= word_cnt + CNT_ONE;
                            end
                        end
                    end
                    C_GAP: begin
                        if (gap_cnt == gap_q - CNT_ONE) begin
                            gap_cnt <= '0;
                            state   <= C_BURST;
                        end else begin
                            gap_cnt <= gap_cnt + CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end

`ifdef PE_FEEDER_CHECKSUM_EN
        localparam int CS_W = DATA_WIDTH + CNT_WIDTH;
        logic [CS_W-1:0] sum;

        assign checksum[ch*CS_W +: CS_W] = sum;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum <= '0;
            end else if (abort || start_ok) begin
                sum <= '0;
            end else if (xfer) begin
                sum <= sum + CS_W'(word);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_state        <= G_IDLE;
            post_dly       <= '0;
            dly_cnt        <= '0;
            busy           <= 1'b0;
            start_psum_out <= 1'b0;
        end else if (abort) begin
            g_state        <= G_IDLE;
            dly_cnt        <= '0;
            busy           <= 1'b0;
            start_psum_out <= 1'b0;
        end else begin
            start_psum_out <= 1'b0;
            case (g_state)
                G_IDLE: begin
                    if (start) begin
                        g_state  <= G_RUN;
                        post_dly <= cfg_post_delay;
                        busy     <= 1'b1;
                    end
                end
                G_RUN: begin
                    if (&ch_done) begin
                        dly_cnt <= '0;
                        if (post_dly == '0) begin
                            g_state        <= G_PULSE;
                            start_psum_out <= 1'b1;
                        end else begin
                            g_state <= G_WAIT;
                        end
                    end
                end
                G_WAIT: begin
                    if (dly_cnt == post_dly - CNT_ONE) begin
                        g_state        <= G_PULSE;
                        start_psum_out <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + CNT_ONE;
                    end
                end
                default: begin
                    g_state <= G_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
Synthesizable multi-channel bus-side data feeder for the PE array. Each channel streams an incrementing word sequence in programmable bursts separated by idle gaps, throttled by the target PE FIFO full flag. Channels are typically fmap, weight and psum_in. When all enabled channels finish, the block waits a programmable delay and then issues a one-cycle start_psum_out pulse. Used for PE bring-up and as the array-level load sequencer.

Parameters:
NUM_CH, 3, number of independent stream channels.
DATA_WIDTH, 16, word width per channel.
CNT_WIDTH, 8, width of the burst-length, burst-count, gap and delay fields.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse; launches all channels enabled in cfg_ch_en.
abort  in  1  synchronous soft clear to idle; higher priority than start.
cfg_ch_en  in  NUM_CH  channel enable mask, sampled on start.
cfg_base  in  NUM_CH*DATA_WIDTH  first word per channel.
cfg_burst_len  in  NUM_CH*CNT_WIDTH  words per burst.
cfg_num_bursts  in  NUM_CH*CNT_WIDTH  bursts per channel.
cfg_gap  in  NUM_CH*CNT_WIDTH  idle cycles between bursts.
cfg_post_delay  in  CNT_WIDTH  cycles from all-done to start_psum_out.
fifo_full  in  NUM_CH  per-channel PE FIFO full (backpressure).
data_out  out  NUM_CH*DATA_WIDTH  current word per channel.
data_en  out  NUM_CH  word transfer strobe per channel.
ch_done  out  NUM_CH  channel finished (level).
busy  out  1  global FSM not idle.
start_psum_out  out  1  one-cycle pulse after post delay.

Behaviour:
- Reset: data_out=0, data_en=0, ch_done=0, busy=0, start_psum_out=0; all FSMs idle; counters 0.
- All cfg_* fields are latched on an accepted start and ignored afterwards. start is ignored while busy=1.
- Per-channel FSM states: C_IDLE, C_BURST, C_GAP, C_DONE.
- Transition from C_IDLE on start:
  - Channel enabled, burst_len>0 and num_bursts>0: go to C_BURST; data_out<=base.
  - Otherwise: go straight to C_DONE.
- data_en[ch] = (state==C_BURST) & !fifo_full[ch]. This is combinational from registered state.
  - A word transfers on every clk edge where data_en=1.
  - After each transfer, data_out increments by 1 next cycle, wrapping modulo 2^DATA_WIDTH.
  - The sequence continues across bursts; it does not reload from base.
- While fifo_full=1 in C_BURST: data_out holds, counters hold, no timeout.
- End of burst (last word transferred):
  - Last burst: go to C_DONE.
  - Else gap>0: go to C_GAP for exactly gap cycles.
  - Else gap=0: stay in C_BURST, so there is no bubble.
- C_GAP then returns to C_BURST.
- C_DONE: ch_done=1. It holds until the next accepted start or abort.
- Global FSM states: G_IDLE, G_RUN, G_WAIT, G_PULSE.
  - start in G_IDLE goes to G_RUN and sets busy=1.
  - When all ch_done=1, go to G_WAIT and count cfg_post_delay cycles (0 means skip).
  - G_PULSE: start_psum_out=1 for one cycle, then G_IDLE and busy=0. ch_done stays high.
- Latency: data_en can first assert 1 cycle after the start edge. start_psum_out asserts post_delay+1 cycles after the cycle in which all ch_done first read 1.
- abort:
  - Every FSM goes idle next cycle; data_en=0, ch_done=0, busy=0; no start_psum_out.
  - data_out holds its last value.
  - abort and start in the same cycle resolve as abort.
- Async reset mid-stream: immediate return to reset values; no partial state persists.
- All-disabled mask on start: ch_done all set next cycle, then the normal post-delay pulse.

Optional Feature:
- Macro: PE_FEEDER_CHECKSUM_EN.
- When defined:
  - Adds output checksum, NUM_CH*(DATA_WIDTH+CNT_WIDTH) bits wide.
  - Per channel it is the running sum of every transferred word, wrapping at its width.
  - Cleared on start, abort and reset; holds after done.
- When undefined: the port and logic are absent.

Test Plan:
- Single channel 0 (base=1, len=6, bursts=2, gap=20), fifo_full=0 -> data_en high for words 1..6, 20 idle cycles, then 7..12; ch_done[0]=1; start_psum_out 1 cycle after post_delay=0.
- Weight channel (base=1, len=9, bursts=4, gap=0), fifo_full toggled every 3 cycles -> 36 transfers of 1..36 with no duplicates or gaps in value; data_out frozen while full.
- Three channels launched together with differing lengths, post_delay=200 -> start_psum_out fires exactly 201 cycles after the slowest channel's done cycle.
- base=16'hFFFE, len=4, bursts=1 -> words FFFE, FFFF, 0000, 0001.
- abort asserted mid-burst, and start+abort in the same cycle -> all idle, busy=0, no start_psum_out; a later start relaunches from the newly latched base.
- With PE_FEEDER_CHECKSUM_EN, ch0 base=1, len=6, bursts=1 -> checksum[0]=21; cleared on next start.
